// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Latency: accept edge plus WIDTH RUN cycles, then a one-cycle DONE pulse. No backpressure; start is ignored while busy.
module mul_div_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    input  logic [ADDR_W-1:0] dest_in,
    output logic              busy,
    output logic              done,
    output logic              regwrite,
    output logic [ADDR_W-1:0] address_dest,
    output logic [WIDTH-1:0]  data_dest,
    output logic              div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [1:0]          op_q;
    logic [WIDTH-1:0]    opnd_q;
    logic [WIDTH-1:0]    hi_q, lo_q;
    logic [ADDR_W-1:0]   dest_q;
    logic [CW-1:0]       cnt_q;
    logic                busy_q, done_q, dbz_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WIDTH-1:0]    data_q;

    logic [WIDTH-1:0]    hi_d, lo_d;
    logic [WIDTH:0]      sum;
    logic [WIDTH:0]      trial;
    logic                ge;

    // hi_q is the upper product half (MUL) or the partial remainder (DIV);
    // lo_q is the multiplier shifting out (MUL) or dividend in / quotient out (DIV).
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        sum   = '0;
        trial = '0;
        ge    = 1'b0;
        if (!op_q[1]) begin
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
            trial = {hi_q, lo_q[WIDTH-1]};
            ge    = trial >= {1'b0, opnd_q};
            hi_d  = ge ? trial[WIDTH-1:0] - opnd_q : trial[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], ge};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        opnd_q  <= op[1] ? operand_b : operand_a;
                        lo_q    <= op[1] ? operand_a : operand_b;
                        hi_q    <= '0;
                        dest_q  <= dest_in;
                        cnt_q   <= CW'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        // A zero divisor needs no special path: every trial subtract
                        // succeeds, giving all-ones quotient and remainder = dividend.
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        data_q  <= op_q[0] ? hi_d : lo_d;
                        addr_q  <= dest_q;
                        dbz_q   <= op_q[1] && (opnd_q == '0);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign regwrite     = done_q;
    assign address_dest = addr_q;
    assign data_dest    = data_q;
    assign div_by_zero  = dbz_q;
endmodule
